// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// Optional locked bursts with DMEM_ARB_BURST_EN (adds lock0/lock1, MAX_BURST).
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
`ifdef DMEM_ARB_BURST_EN
  parameter int MAX_BURST = 4,
`endif
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
`ifdef DMEM_ARB_BURST_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic          last_gnt;
  logic          sel;
  logic          gnt_any;
  logic          we_sel;
  logic          hold;
  logic [AW-1:0] addr_sel;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wd_sel;
  logic [DW-1:0] wd_q;
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] pp;

`ifdef DMEM_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_cnt;
  logic          lock_last;
  logic          req_last;
  logic          req_oth;

  // The last-granted port keeps the bus while locked, unless it has
  // used up its burst and the other side is waiting.
  always_comb begin
    lock_last = last_gnt ? lock1 : lock0;
    req_last  = last_gnt ? req1 : req0;
    req_oth   = last_gnt ? req0 : req1;
    hold      = lock_last & req_last
              & ~(req_oth & (burst_cnt >= CW'(MAX_BURST)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (!gnt_any) begin
      burst_cnt <= '0;
    end else if (sel != last_gnt) begin
      burst_cnt <= CW'(1);
    end else if (burst_cnt != CW'(MAX_BURST)) begin
      burst_cnt <= burst_cnt + CW'(1);
    end
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    sel      = (req0 & req1) ? (hold ? last_gnt : ~last_gnt) : req1;
    gnt_any  = (req0 | req1) & ~rst;
    we_sel   = sel ? we1 : we0;
    addr_sel = sel ? addr1 : addr0;
    wd_sel   = sel ? wdata1 : wdata0;
  end

  assign gnt0     = gnt_any & ~sel;
  assign gnt1     = gnt_any & sel;
  assign mem_we   = gnt_any & we_sel;
  assign mem_addr = rst ? '0 : (gnt_any ? addr_sel : addr_q);
  assign mem_wd   = rst ? '0 : (gnt_any ? wd_sel : wd_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      addr_q   <= '0;
      wd_q     <= '0;
    end else if (gnt_any) begin
      last_gnt <= sel;
      addr_q   <= addr_sel;
      wd_q     <= wd_sel;
    end
  end

  // Tag pipeline: valid bit plus port id, one stage per cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pp <= '0;
    end else begin
      pv[0] <= gnt_any & ~we_sel;
      pp[0] <= sel;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
      end
    end
  end

  assign rvalid0 = pv[RD_LAT-1] & ~pp[RD_LAT-1] & ~rst;
  assign rvalid1 = pv[RD_LAT-1] & pp[RD_LAT-1] & ~rst;
  assign rdata0  = rvalid0 ? mem_rd : '0;
  assign rdata1  = rvalid1 ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
// Words reset to 0x1000_0000 + word index whenever rst is high.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, gnt1, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
`ifdef DMEM_ARB_BURST_EN
  logic        lock0, lock1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef DMEM_ARB_BURST_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wd;
    end
    mem_rd <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    int p;
    rst = 1'b1;
`ifdef DMEM_ARB_BURST_EN
    lock0 = 1'b0;
    lock1 = 1'b0;
`endif
    drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);

    // reset held two cycles with both ports requesting
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt0", 32'(gnt0), 0);
      chk("rst_gnt1", 32'(gnt1), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_rv0", 32'(rvalid0), 0);
      chk("rst_rv1", 32'(rvalid1), 0);
      chk("rst_addr", mem_addr, 0);
      next_cycle();
    end

    // A: port 0 writes, port 1 also asks; port 0 wins first
    rst = 1'b0;
    drive(1, 1, 32'h10, 32'hDEAD_BEEF, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("a_gnt0", 32'(gnt0), 1);
    chk("a_gnt1", 32'(gnt1), 0);
    chk("a_we", 32'(mem_we), 1);
    chk("a_addr", mem_addr, 32'h10);
    chk("a_wd", mem_wd, 32'hDEAD_BEEF);
    next_cycle();

    // B: port 0 reads it back
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b_gnt0", 32'(gnt0), 1);
    chk("b_we", 32'(mem_we), 0);
    chk("b_rv0", 32'(rvalid0), 0);
    next_cycle();

    // C: idle, data returns
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("c_rv0", 32'(rvalid0), 1);
    chk("c_rd0", rdata0, 32'hDEAD_BEEF);
    chk("c_rv1", 32'(rvalid1), 0);
    chk("c_rd1", rdata1, 0);
    chk("c_we", 32'(mem_we), 0);
    chk("c_hold", mem_addr, 32'h10);
    next_cycle();

    // D: lone port-1 read so contention starts with port 0
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("d_gnt1", 32'(gnt1), 1);
    next_cycle();

    // E: six cycles of contention
    drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("e_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      chk("e_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      chk("e_addr", mem_addr, (i % 2 == 1) ? 32'h40 : 32'h0);
      p = (i == 0) ? 1 : (i - 1) % 2;
      chk("e_rv0", 32'(rvalid0), 32'(p == 0));
      chk("e_rv1", 32'(rvalid1), 32'(p == 1));
      chk("e_rd0", rdata0, (p == 0) ? 32'h1000_0000 : 32'h0);
      chk("e_rd1", rdata1, (p == 1) ? 32'h1000_0010 : 32'h0);
      next_cycle();
    end

    // F: tail of contention
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("f_rv0", 32'(rvalid0), 0);
    chk("f_rv1", 32'(rvalid1), 1);
    chk("f_rd1", rdata1, 32'h1000_0010);
    next_cycle();

    // G: port-1 read, then reset in H kills it
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("g_gnt1", 32'(gnt1), 1);
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("h_rv1", 32'(rvalid1), 0);
    chk("h_addr", mem_addr, 0);
    next_cycle();

    // I: port-0 read, then I2 reset to restore last_gnt=1
    rst = 1'b0;
    drive(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("i_rv1", 32'(rvalid1), 0);
    chk("i_gnt0", 32'(gnt0), 1);
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("i2_rv0", 32'(rvalid0), 0);
    next_cycle();

    // J: both request, port 0 wins after reset
    rst = 1'b0;
    drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("j_gnt0", 32'(gnt0), 1);
    chk("j_gnt1", 32'(gnt1), 0);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("j2_gnt1", 32'(gnt1), 1);
    chk("j2_rd0", rdata0, 32'h1000_0000);
    next_cycle();

    // K/L/M/N: write/read ordering on 0x20
    drive(1, 0, 32'h20, 32'h0, 1, 1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("k_gnt0", 32'(gnt0), 1);
    chk("k_gnt1", 32'(gnt1), 0);
    chk("k_we", 32'(mem_we), 0);
    chk("k_rd1", rdata1, 32'h1000_0010);
    chk("k_rd0", rdata0, 0);
    next_cycle();
    @(negedge clk);
    chk("l_gnt1", 32'(gnt1), 1);
    chk("l_gnt0", 32'(gnt0), 0);
    chk("l_we", 32'(mem_we), 1);
    chk("l_wd", mem_wd, 32'h1234_5678);
    chk("l_rv0", 32'(rvalid0), 1);
    chk("l_rd0", rdata0, 32'h1000_0008);
    next_cycle();
    drive(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("m_gnt0", 32'(gnt0), 1);
    chk("m_rv0", 32'(rvalid0), 0);
    chk("m_rv1", 32'(rvalid1), 0);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("n_rv0", 32'(rvalid0), 1);
    chk("n_rd0", rdata0, 32'h1234_5678);
    chk("n_we", 32'(mem_we), 0);
    chk("n_hold", mem_addr, 32'h20);
    next_cycle();

`ifdef DMEM_ARB_BURST_EN
    // locked burst from port 1 against a waiting port 0
    rst = 1'b1;
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    lock1 = 1'b1;
    drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("burst_gnt1", 32'(gnt1), 32'(i < 4));
      chk("burst_gnt0", 32'(gnt0), 32'(i == 4));
      next_cycle();
    end
    lock1 = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
